// File: rtl/srp_correlator_if.sv
// Read-only BRAM port bundle used by the SRP correlator.
// The correlator drives en/we/addr and receives dout one cycle after en.
interface srp_correlator_if #(
  parameter int ADDR_W = 12
) ();
  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dout;

  modport master (output en, output we, output addr, input dout);
  modport slave  (input en, input we, input addr, output dout);
endinterface

// File: rtl/srp_correlator.sv
// Shapiro-Rudin-Park correlator: slides a +/-1 chip sequence over the sample
// buffer, accumulates the signed correlation for every lag and reports the
// lag with the largest value (earliest lag wins on ties).
module srp_correlator #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 2096,
  parameter int SEQ_LEN  = 64,
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = SAMPLE_W + $clog2(SEQ_LEN) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SEQ_LEN-1:0]      seq,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       peak_idx,
  output logic signed [ACC_W-1:0] peak_val,
  srp_correlator_if.master        bram
);

  localparam int NLAGS = DEPTH - SEQ_LEN + 1;
  localparam int KW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [KW-1:0]     K_LAST   = KW'(SEQ_LEN - 1);
  localparam logic [ADDR_W-1:0] LAG_LAST = ADDR_W'(NLAGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       lag_q, lag_d;
  logic [KW-1:0]           k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SEQ_LEN-1:0]      seq_q, seq_d;
  logic [ADDR_W-1:0]       peak_idx_q, peak_idx_d;
  logic signed [ACC_W-1:0] peak_val_q, peak_val_d;
  // Read pipeline tag: marks the cycle in which dout carries the datum for chip rd_k_q.
  logic                    rd_vld_q, rd_vld_d;
  logic [KW-1:0]           rd_k_q, rd_k_d;

  logic signed [ACC_W-1:0] sample_ext;
  logic                    unused_dout_hi;

  // Only the low SAMPLE_W bits carry the sample; the rest of the word is don't-care.
  assign sample_ext     = {{(ACC_W - SAMPLE_W){bram.dout[SAMPLE_W-1]}}, bram.dout[SAMPLE_W-1:0]};
  assign unused_dout_hi = ^bram.dout[31:SAMPLE_W];

  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) || (state_q == S_CMP);
  assign done      = (state_q == S_DONE);
  assign bram.en   = (state_q == S_FETCH);
  assign bram.we   = 1'b0;
  assign bram.addr = lag_q + ADDR_W'(k_q);
  assign peak_idx  = peak_idx_q;
  assign peak_val  = peak_val_q;

  // State and datapath registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lag_q      <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      seq_q      <= '0;
      peak_idx_q <= '0;
      peak_val_q <= '0;
      rd_vld_q   <= 1'b0;
      rd_k_q     <= '0;
    end else begin
      state_q    <= state_d;
      lag_q      <= lag_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      seq_q      <= seq_d;
      peak_idx_q <= peak_idx_d;
      peak_val_q <= peak_val_d;
      rd_vld_q   <= rd_vld_d;
      rd_k_q     <= rd_k_d;
    end
  end

  // Next-state logic: issue reads, accumulate returning samples, track the peak.
  always_comb begin
    state_d    = state_q;
    lag_d      = lag_q;
    k_d        = k_q;
    acc_d      = acc_q;
    seq_d      = seq_q;
    peak_idx_d = peak_idx_q;
    peak_val_d = peak_val_q;
    rd_vld_d   = 1'b0;
    rd_k_d     = rd_k_q;

    // The datum issued last cycle is returning now; weight it by its chip.
    if (rd_vld_q) begin
      if (seq_q[rd_k_q]) acc_d = acc_q + sample_ext;
      else               acc_d = acc_q - sample_ext;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          lag_d      = '0;
          k_d        = '0;
          acc_d      = '0;
          seq_d      = seq;
          peak_idx_d = '0;
          peak_val_d = '0;
        end
      end
      S_FETCH: begin
        rd_vld_d = 1'b1;
        rd_k_d   = k_q;
        if (k_q == K_LAST) state_d = S_DRAIN;
        else               k_d     = k_q + 1'b1;
      end
      S_DRAIN: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        // Strict compare keeps the earliest lag on ties.
        if ((lag_q == '0) || (acc_q > peak_val_q)) begin
          peak_val_d = acc_q;
          peak_idx_d = lag_q;
        end
        if (lag_q == LAG_LAST) begin
          state_d = S_DONE;
        end else begin
          lag_d   = lag_q + 1'b1;
          k_d     = '0;
          acc_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_srp_correlator.sv
// Self-checking bench for srp_correlator with a small buffer (DEPTH=16, SEQ_LEN=4).
module tb_srp_correlator;

  localparam int ADDR_W   = 12;
  localparam int DEPTH    = 16;
  localparam int SEQ_LEN  = 4;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = SAMPLE_W + $clog2(SEQ_LEN) + 1;
  localparam int NLAGS    = DEPTH - SEQ_LEN + 1;
  localparam int RUN_CYC  = NLAGS * (SEQ_LEN + 2) + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [SEQ_LEN-1:0]      seq;
  logic                    busy;
  logic                    done;
  logic [ADDR_W-1:0]       peak_idx;
  logic signed [ACC_W-1:0] peak_val;

  srp_correlator_if #(.ADDR_W(ADDR_W)) bram_if ();

  srp_correlator #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEQ_LEN(SEQ_LEN), .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seq(seq),
    .busy(busy), .done(done), .peak_idx(peak_idx), .peak_val(peak_val),
    .bram(bram_if)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  int we_bad   = 0;
  int addr_bad = 0;
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // One-cycle-latency BRAM model plus bus hygiene monitors.
  always @(posedge clk) begin
    if (bram_if.we !== 1'b0) we_bad <= we_bad + 1;
    if (bram_if.en === 1'b1) begin
      if (bram_if.addr >= ADDR_W'(DEPTH)) addr_bad <= addr_bad + 1;
      bram_if.dout <= mem[bram_if.addr[3:0]];
    end
  end

  // Reference: direct sum over every lag, first maximum wins.
  task automatic model(input logic [SEQ_LEN-1:0] s, output int eidx, output int eval);
    int sum;
    logic [15:0] w;
    eidx = 0;
    eval = 0;
    for (int lag = 0; lag < NLAGS; lag++) begin
      sum = 0;
      for (int k = 0; k < SEQ_LEN; k++) begin
        w = mem[lag + k][15:0];
        if (s[k]) sum += int'($signed(w));
        else      sum -= int'($signed(w));
      end
      if (lag == 0 || sum > eval) begin
        eval = sum;
        eidx = lag;
      end
    end
  endtask

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < DEPTH; i++) mem[i] = v;
  endtask

  // Launch a search and wait (bounded) for done; cyc=-1 on timeout.
  task automatic run_search(input logic [SEQ_LEN-1:0] s, output int cyc, output logic busy1);
    @(negedge clk);
    seq   = s;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc   = 0;
    busy1 = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) busy1 = busy;
    end while (done !== 1'b1 && cyc < 400);
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    seq   = '0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, done, bram_if.en, bram_if.addr, peak_idx, peak_val} !== '0)
      $display("FAIL reset_state: busy=%b done=%b en=%b addr=%0d idx=%0d val=%0d, want all 0",
               busy, done, bram_if.en, bram_if.addr, peak_idx, peak_val);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int cyc;
    logic b1;
    fill_mem(32'h0);
    run_search(4'b1011, cyc, b1);
    chk_cnt++;
    if (cyc != RUN_CYC) $display("FAIL zero_latency: done at cycle %0d, want %0d", cyc, RUN_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (b1 !== 1'b1) $display("FAIL zero_busy: busy=%b in first cycle, want 1", b1);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL zero_busy_done: busy=%b in done cycle, want 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if (peak_idx !== 0 || peak_val !== 0)
      $display("FAIL zero_result: idx=%0d val=%0d, want idx=0 val=0", peak_idx, peak_val);
    else pass_cnt++;
    $display("zero: cycles=%0d idx=%0d val=%0d", cyc, peak_idx, peak_val);
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL zero_done_pulse: done=%b after pulse, want 0", done);
    else pass_cnt++;
  endtask

  task automatic load_pattern_at(input int base);
    mem[base]     = 32'sd100;
    mem[base + 1] = 32'sd100;
    mem[base + 2] = -32'sd100;
    mem[base + 3] = 32'sd100;
  endtask

  task automatic test_single_peak();
    int cyc;
    logic b1;
    fill_mem(32'h0);
    load_pattern_at(5);
    run_search(4'b1011, cyc, b1);
    chk_cnt++;
    if (cyc != RUN_CYC || peak_idx !== 5 || peak_val !== 400)
      $display("FAIL single_peak: cyc=%0d idx=%0d val=%0d, want cyc=%0d idx=5 val=400",
               cyc, peak_idx, peak_val, RUN_CYC);
    else pass_cnt++;
    $display("single_peak: cycles=%0d idx=%0d val=%0d", cyc, peak_idx, peak_val);
  endtask

  task automatic test_tie();
    int cyc;
    logic b1;
    fill_mem(32'h0);
    load_pattern_at(2);
    load_pattern_at(9);
    run_search(4'b1011, cyc, b1);
    chk_cnt++;
    if (peak_idx !== 2 || peak_val !== 400)
      $display("FAIL tie_first: idx=%0d val=%0d, want idx=2 val=400", peak_idx, peak_val);
    else pass_cnt++;
    $display("tie: cycles=%0d idx=%0d val=%0d", cyc, peak_idx, peak_val);
  endtask

  task automatic test_upper_bits();
    int cyc;
    logic b1;
    int pv;
    fill_mem(32'hABCD8000);
    run_search(4'b1111, cyc, b1);
    pv = peak_val;
    chk_cnt++;
    if (peak_idx !== 0 || pv != -131072)
      $display("FAIL upper_bits: idx=%0d val=%0d, want idx=0 val=-131072", peak_idx, pv);
    else pass_cnt++;
    $display("upper_bits: cycles=%0d idx=%0d val=%0d", cyc, peak_idx, pv);
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic b1;
    fill_mem(32'h0);
    load_pattern_at(5);
    @(negedge clk);
    seq   = 4'b1011;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (29) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({busy, done, bram_if.en, peak_idx, peak_val} !== '0)
      $display("FAIL mid_reset_async: busy=%b done=%b en=%b idx=%0d val=%0d, want all 0",
               busy, done, bram_if.en, peak_idx, peak_val);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({busy, done, bram_if.en, bram_if.addr} !== '0)
      $display("FAIL mid_reset_hold: busy=%b done=%b en=%b addr=%0d, want all 0",
               busy, done, bram_if.en, bram_if.addr);
    else pass_cnt++;
    rst = 1'b0;
    run_search(4'b1011, cyc, b1);
    chk_cnt++;
    if (cyc != RUN_CYC || peak_idx !== 5 || peak_val !== 400)
      $display("FAIL mid_reset_restart: cyc=%0d idx=%0d val=%0d, want cyc=%0d idx=5 val=400",
               cyc, peak_idx, peak_val, RUN_CYC);
    else pass_cnt++;
    $display("mid_reset_restart: cycles=%0d idx=%0d val=%0d", cyc, peak_idx, peak_val);
  endtask

  task automatic test_start_ignored();
    int cyc;
    int ndone;
    int first;
    int eidx, ev, pv;
    fill_mem(32'h0);
    load_pattern_at(5);
    model(4'b1011, eidx, ev);
    @(negedge clk);
    seq   = 4'b1011;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc   = 0;
    ndone = 0;
    first = -1;
    while (cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        start = 1'b1;
        seq   = 4'b0100;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = cyc;
      end
    end
    start = 1'b0;
    chk_cnt++;
    if (ndone != 1 || first != RUN_CYC)
      $display("FAIL restart_ignored: %0d done pulses first at %0d, want 1 at %0d", ndone, first, RUN_CYC);
    else pass_cnt++;
    pv = peak_val;
    chk_cnt++;
    if (peak_idx !== eidx || pv != ev)
      $display("FAIL restart_result: idx=%0d val=%0d, want idx=%0d val=%0d", peak_idx, pv, eidx, ev);
    else pass_cnt++;
    $display("start_ignored: pulses=%0d first=%0d idx=%0d val=%0d", ndone, first, peak_idx, pv);
  endtask

  task automatic test_random();
    int cyc;
    logic b1;
    logic [SEQ_LEN-1:0] s;
    int eidx, ev, pv;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (it < 3) mem[i] = $urandom;
        else        mem[i] = {$urandom_range(0, 65535), 16'(int'($urandom_range(0, 6)) - 3)};
      end
      s = SEQ_LEN'($urandom);
      model(s, eidx, ev);
      run_search(s, cyc, b1);
      pv = peak_val;
      chk_cnt++;
      if (cyc != RUN_CYC || peak_idx !== eidx || pv != ev)
        $display("FAIL random_%0d: cyc=%0d idx=%0d val=%0d, want cyc=%0d idx=%0d val=%0d",
                 it, cyc, peak_idx, pv, RUN_CYC, eidx, ev);
      else pass_cnt++;
      $display("random_%0d: seq=%b idx=%0d val=%0d", it, s, peak_idx, pv);
    end
  endtask

  task automatic test_bus_hygiene();
    chk_cnt++;
    if (we_bad != 0) $display("FAIL bram_we: %0d cycles with we!=0, want 0", we_bad);
    else pass_cnt++;
    chk_cnt++;
    if (addr_bad != 0) $display("FAIL bram_addr_bound: %0d reads beyond DEPTH-1, want 0", addr_bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_peak();
    test_tie();
    test_upper_bits();
    test_reset_mid_run();
    test_start_ignored();
    test_random();
    test_bus_hygiene();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
